// File: rtl/tcam_ctrl_pkg.sv
// Shared types and geometry for the 32-rule x 28-bit TCAM front-end controller.
package tcam_ctrl_pkg;

  localparam int unsigned NUM_RULES  = 32;
  localparam int unsigned KEY_W      = 28;
  localparam int unsigned CHUNK_W    = 7;
  localparam int unsigned NUM_CHUNKS = 4;
  localparam int unsigned NUM_ROWS   = 512;

  typedef enum logic [1:0] {INIT, IDLE, WRITE} state_e;

  typedef struct packed {
    logic             valid;
    logic [KEY_W-1:0] value;
    logic [KEY_W-1:0] care;
  } rule_t;

  localparam int unsigned RULE_W = $bits(rule_t);

  typedef struct packed {
    logic [CHUNK_W-1:0] value;
    logic [CHUNK_W-1:0] care;
  } chunk_t;

  // Chunk 0 is the most significant 7 key bits, chunk 3 the least.
  function automatic chunk_t chunk_sel(rule_t r, logic [1:0] c);
    chunk_t ch;
    case (c)
      2'd0:    ch = '{value: r.value[27:21], care: r.care[27:21]};
      2'd1:    ch = '{value: r.value[20:14], care: r.care[20:14]};
      2'd2:    ch = '{value: r.value[13:7],  care: r.care[13:7]};
      default: ch = '{value: r.value[6:0],   care: r.care[6:0]};
    endcase
    return ch;
  endfunction

endpackage

// File: rtl/tcam_row_gen.sv
// One byte lane of a TCAM row: bit j is set when rule j of the lane accepts row key k in chunk c.
module tcam_row_gen
  import tcam_ctrl_pkg::*;
(
  input  logic [8*RULE_W-1:0] rules_i,
  input  logic [1:0]          chunk_i,
  input  logic [CHUNK_W-1:0]  key_i,
  output logic [7:0]          byte_o
);

  for (genvar j = 0; j < 8; j++) begin : g_rule
    rule_t  r;
    chunk_t ch;
    assign r         = rule_t'(rules_i[j*RULE_W +: RULE_W]);
    assign ch        = chunk_sel(r, chunk_i);
    assign byte_o[j] = r.valid & (((key_i ^ ch.value) & ch.care) == '0);
  end

endmodule

// File: rtl/tcam_32x28_ctrl.sv
// Front-end controller for the 32x28 SRAM-backed TCAM macro: init clear, rule rewrites, searches.
// Define TCAM_SEARCH_PREEMPT_EN to let searches steal macro cycles from an ongoing rule rewrite.
module tcam_32x28_ctrl
  import tcam_ctrl_pkg::*;
#(
  parameter int unsigned RD_LAT        = 1,
  parameter int unsigned INIT_ON_RESET = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        search_valid_i,
  input  logic [27:0] search_key_i,
  output logic        search_ready_o,
  output logic        result_valid_o,
  output logic [5:0]  result_o,
  input  logic        upd_valid_i,
  output logic        upd_ready_o,
  input  logic [4:0]  upd_idx_i,
  input  logic        upd_install_i,
  input  logic [27:0] upd_value_i,
  input  logic [27:0] upd_care_i,
  output logic        upd_done_o,
  output logic        busy_o,
  output logic        tcam_csb_o,
  output logic        tcam_web_o,
  output logic [3:0]  tcam_wmask_o,
  output logic [27:0] tcam_addr_o,
  output logic [31:0] tcam_wdata_o,
  input  logic [5:0]  tcam_rdata_i
);

  localparam logic [8:0] LastRow = 9'(NUM_ROWS - 1);

  state_e            state_q, state_d;
  logic [8:0]        cnt_q, cnt_d;
  logic [1:0]        lane_q, lane_d;
  rule_t             rules_q [NUM_RULES];
  rule_t             rules_d [NUM_RULES];
  logic [RD_LAT-1:0] pipe_q, pipe_d;

  logic                search_ready, search_accept;
  logic                upd_ready, upd_accept, write_en;
  logic [8*RULE_W-1:0] lane_rules;
  logic [7:0]          lane_byte;

`ifdef TCAM_SEARCH_PREEMPT_EN
  assign search_ready = rst_ni & ((state_q == IDLE) | (state_q == WRITE));
`else
  assign search_ready = rst_ni & (state_q == IDLE);
`endif

  assign search_accept = search_valid_i & search_ready;
  assign upd_ready     = rst_ni & (state_q == IDLE) & ~search_valid_i;
  assign upd_accept    = upd_valid_i & upd_ready;
  // A search always wins the macro; a write in WRITE simply retries on the next cycle.
  assign write_en      = rst_ni & ((state_q == INIT) | ((state_q == WRITE) & ~search_accept));

  always_comb begin
    lane_rules = '0;
    for (int j = 0; j < 8; j++) begin
      lane_rules[j*RULE_W +: RULE_W] = rules_q[{lane_q, 3'(j)}];
    end
  end

  tcam_row_gen u_row_gen (
    .rules_i (lane_rules),
    .chunk_i (cnt_q[8:7]),
    .key_i   (cnt_q[6:0]),
    .byte_o  (lane_byte)
  );

  always_comb begin
    pipe_d    = pipe_q << 1;
    pipe_d[0] = search_accept;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= (INIT_ON_RESET != 0) ? INIT : IDLE;
      cnt_q   <= '0;
      lane_q  <= '0;
      pipe_q  <= '0;
      for (int i = 0; i < NUM_RULES; i++) begin
        rules_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lane_q  <= lane_d;
      pipe_q  <= pipe_d;
      rules_q <= rules_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lane_d  = lane_q;
    rules_d = rules_q;
    unique case (state_q)
      INIT: begin
        cnt_d = cnt_q + 9'd1;
        if (cnt_q == LastRow) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (upd_accept) begin
          rules_d[upd_idx_i] = '{valid: upd_install_i, value: upd_value_i, care: upd_care_i};
          lane_d  = upd_idx_i[4:3];
          cnt_d   = '0;
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (write_en) begin
          cnt_d = cnt_q + 9'd1;
          if (cnt_q == LastRow) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tcam_csb_o   = 1'b1;
    tcam_web_o   = 1'b1;
    tcam_wmask_o = 4'h0;
    tcam_addr_o  = '0;
    tcam_wdata_o = '0;
    upd_done_o   = 1'b0;
    if (search_accept) begin
      tcam_csb_o  = 1'b0;
      tcam_addr_o = search_key_i;
    end else if (write_en) begin
      tcam_csb_o  = 1'b0;
      tcam_web_o  = 1'b0;
      tcam_addr_o = {19'd0, cnt_q};
      if (state_q == INIT) begin
        tcam_wmask_o = 4'hF;
      end else begin
        tcam_wmask_o = 4'b0001 << lane_q;
        tcam_wdata_o = 32'(lane_byte) << {lane_q, 3'b000};
        upd_done_o   = (cnt_q == LastRow);
      end
    end
  end

  assign search_ready_o = search_ready;
  assign upd_ready_o    = upd_ready;
  assign busy_o         = rst_ni & (state_q != IDLE);
  assign result_valid_o = rst_ni & pipe_q[RD_LAT-1];
  assign result_o       = result_valid_o ? tcam_rdata_i : 6'd0;

endmodule

// File: tb/tb_tcam_32x28_ctrl.sv
// Self-checking bench for tcam_32x28_ctrl with a behavioural TCAM macro and rule-table reference.
module tb_tcam_32x28_ctrl;

  logic        clk;
  logic        rst_ni;
  logic        search_valid_i;
  logic [27:0] search_key_i;
  logic        search_ready_o;
  logic        result_valid_o;
  logic [5:0]  result_o;
  logic        upd_valid_i;
  logic        upd_ready_o;
  logic [4:0]  upd_idx_i;
  logic        upd_install_i;
  logic [27:0] upd_value_i;
  logic [27:0] upd_care_i;
  logic        upd_done_o;
  logic        busy_o;
  logic        tcam_csb_o;
  logic        tcam_web_o;
  logic [3:0]  tcam_wmask_o;
  logic [27:0] tcam_addr_o;
  logic [31:0] tcam_wdata_o;
  logic [5:0]  tcam_rdata_i;

  int checks = 0;
  int errors = 0;

  tcam_32x28_ctrl #(
    .RD_LAT        (1),
    .INIT_ON_RESET (1)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .search_valid_i (search_valid_i),
    .search_key_i   (search_key_i),
    .search_ready_o (search_ready_o),
    .result_valid_o (result_valid_o),
    .result_o       (result_o),
    .upd_valid_i    (upd_valid_i),
    .upd_ready_o    (upd_ready_o),
    .upd_idx_i      (upd_idx_i),
    .upd_install_i  (upd_install_i),
    .upd_value_i    (upd_value_i),
    .upd_care_i     (upd_care_i),
    .upd_done_o     (upd_done_o),
    .busy_o         (busy_o),
    .tcam_csb_o     (tcam_csb_o),
    .tcam_web_o     (tcam_web_o),
    .tcam_wmask_o   (tcam_wmask_o),
    .tcam_addr_o    (tcam_addr_o),
    .tcam_wdata_o   (tcam_wdata_o),
    .tcam_rdata_i   (tcam_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Macro model: 512 x 32 rows, byte-lane writes, 1-cycle priority-encoded search.
  logic [31:0] mem [512];
  logic [5:0]  rdata_q = 6'd0;
  logic [8:0]  seq = 9'd0;
  logic [3:0]  exp_mask;
  int          wr_total = 0;
  int          wr_bad = 0;
  logic [31:0] lane_bits;

  assign tcam_rdata_i = rdata_q;
  assign lane_bits = {{8{tcam_wmask_o[3]}}, {8{tcam_wmask_o[2]}},
                      {8{tcam_wmask_o[1]}}, {8{tcam_wmask_o[0]}}};

  function automatic logic [5:0] macro_match(input logic [27:0] key);
    logic [31:0] m;
    m = mem[{2'd0, key[27:21]}] & mem[{2'd1, key[20:14]}] &
        mem[{2'd2, key[13:7]}]  & mem[{2'd3, key[6:0]}];
    for (int i = 0; i < 32; i++) begin
      if (m[i] === 1'b1) return 6'(i + 1);
    end
    return 6'd0;
  endfunction

  always @(posedge clk) begin
    if (tcam_csb_o === 1'b0 && tcam_web_o === 1'b1) begin
      rdata_q <= macro_match(tcam_addr_o);
    end
    if (tcam_csb_o === 1'b0 && tcam_web_o === 1'b0) begin
      for (int b = 0; b < 4; b++) begin
        if (tcam_wmask_o[b]) mem[tcam_addr_o[8:0]][8*b +: 8] <= tcam_wdata_o[8*b +: 8];
      end
      wr_total <= wr_total + 1;
      if ((tcam_addr_o !== {19'd0, seq}) || (tcam_wmask_o !== exp_mask) ||
          ((tcam_wdata_o & ~lane_bits) !== 32'd0) ||
          ((exp_mask == 4'hF) && (tcam_wdata_o !== 32'd0))) begin
        wr_bad <= wr_bad + 1;
      end
      seq <= seq + 9'd1;
    end
    if (!rst_ni) seq <= 9'd0;
  end

  // Architectural rule table reference.
  logic        mvalid [32];
  logic [27:0] mval   [32];
  logic [27:0] mcare  [32];

  function automatic logic [5:0] ref_result(input logic [27:0] key);
    for (int r = 0; r < 32; r++) begin
      if (mvalid[r] && (((key ^ mval[r]) & mcare[r]) == 28'h0)) return 6'(r + 1);
    end
    return 6'd0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_apply(input logic [4:0] idx, input logic inst,
                             input logic [27:0] v, input logic [27:0] c);
    mvalid[idx] = inst;
    mval[idx]   = v;
    mcare[idx]  = c;
  endtask

  task automatic wait_init();
    int   w0, b0;
    logic done;
    w0 = wr_total;
    b0 = wr_bad;
    done = 1'b0;
    for (int i = 0; i < 1000 && !done; i++) begin
      @(negedge clk);
      if (i == 0) begin
        chk("init_search_ready", search_ready_o, 1'b0);
        chk("init_upd_ready", upd_ready_o, 1'b0);
      end
      if (busy_o === 1'b0) done = 1'b1;
    end
    chk("init_finished", done, 1'b1);
    chk("init_writes", wr_total - w0, 512);
    chk("init_write_fmt", wr_bad - b0, 0);
    @(posedge clk); #1;
  endtask

  task automatic do_search(input logic [27:0] key);
    search_valid_i = 1'b1;
    search_key_i   = key;
    @(negedge clk);
    chk("search_ready", search_ready_o, 1'b1);
    @(posedge clk); #1;
    search_valid_i = 1'b0;
    @(negedge clk);
    chk("result_valid", result_valid_o, 1'b1);
    chk("result", result_o, ref_result(key));
    @(posedge clk); #1;
  endtask

  task automatic finish_update(input logic hold);
    int   n, nacc, rdy_bad, w0, b0;
    logic got;
    w0 = wr_total;
    b0 = wr_bad;
    n = 0; nacc = 0; rdy_bad = 0; got = 1'b0;
    exp_mask = 4'b0001 << upd_idx_i[4:3];
    for (int i = 1; i <= 800 && !got; i++) begin
`ifdef TCAM_SEARCH_PREEMPT_EN
      search_valid_i = hold && (i >= 100) && (i < 110);
      search_key_i   = 28'($urandom);
`else
      search_valid_i = hold;
`endif
      @(negedge clk);
      if (search_valid_i && search_ready_o) nacc++;
      if (search_ready_o !== 1'b0) rdy_bad++;
      if (upd_done_o === 1'b1) begin
        got = 1'b1;
        n = i;
      end
      @(posedge clk); #1;
    end
    search_valid_i = 1'b0;
    chk("upd_done_seen", got, 1'b1);
`ifdef TCAM_SEARCH_PREEMPT_EN
    chk("upd_latency", n, hold ? 522 : 512);
    if (hold) chk("preempt_searches", nacc, 10);
`else
    chk("upd_latency", n, 512);
    chk("ready_in_write", rdy_bad, 0);
`endif
    chk("upd_writes", wr_total - w0, 512);
    chk("upd_write_fmt", wr_bad - b0, 0);
    chk("busy_after_upd", busy_o, 1'b0);
  endtask

  task automatic do_update(input logic [4:0] idx, input logic inst,
                           input logic [27:0] v, input logic [27:0] c, input logic hold);
    upd_idx_i = idx; upd_install_i = inst; upd_value_i = v; upd_care_i = c;
    upd_valid_i = 1'b1;
    @(negedge clk);
    chk("upd_ready", upd_ready_o, 1'b1);
    @(posedge clk); #1;
    upd_valid_i = 1'b0;
    model_apply(idx, inst, v, c);
    finish_update(hold);
  endtask

  task automatic rand_search(input int n);
    logic [27:0] k;
    int          r;
    for (int i = 0; i < n; i++) begin
      r = $urandom_range(31);
      if ($urandom_range(1) == 1) k = mval[r] ^ (28'($urandom) & ~mcare[r]);
      else k = 28'($urandom);
      do_search(k);
    end
  endtask

  initial begin
    logic [27:0] k, v, c;
    logic [4:0]  idx;
    int          w0;
    rst_ni = 1'b0;
    search_valid_i = 1'b0; search_key_i = '0;
    upd_valid_i = 1'b0; upd_idx_i = '0; upd_install_i = 1'b0;
    upd_value_i = '0; upd_care_i = '0;
    exp_mask = 4'hF;
    for (int r = 0; r < 32; r++) model_apply(5'(r), 1'b0, 28'h0, 28'h0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_csb", tcam_csb_o, 1'b1);
    chk("rst_web", tcam_web_o, 1'b1);
    chk("rst_wmask", tcam_wmask_o, 4'h0);
    chk("rst_addr", tcam_addr_o, 28'h0);
    chk("rst_wdata", tcam_wdata_o, 32'h0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_search_ready", search_ready_o, 1'b0);
    chk("rst_upd_ready", upd_ready_o, 1'b0);
    chk("rst_result_valid", result_valid_o, 1'b0);
    chk("rst_result", result_o, 6'd0);
    chk("rst_upd_done", upd_done_o, 1'b0);
    rst_ni = 1'b1;
    wait_init();
    do_search(28'h0);

    do_update(5'd0, 1'b1, 28'h0ABCDEF, 28'hFFFFFFF, 1'b0);
    do_search(28'h0ABCDEF);
    do_search(28'h0ABCDEE);
    do_update(5'd0, 1'b0, 28'h0ABCDEF, 28'hFFFFFFF, 1'b0);
    do_update(5'd5, 1'b1, 28'($urandom), 28'h0, 1'b0);
    do_update(5'd2, 1'b1, 28'h0ABCDEF, 28'hFFFFFFF, 1'b0);
    do_search(28'h0ABCDEF);
    k = 28'($urandom);
    if (k == 28'h0ABCDEF) k = k ^ 28'h1;
    do_search(k);
    do_update(5'd2, 1'b0, 28'h0ABCDEF, 28'hFFFFFFF, 1'b0);
    do_search(28'h0ABCDEF);

    // Search and update offered together: search first, update on the next cycle.
    k = 28'($urandom);
    v = 28'($urandom);
    c = 28'($urandom) & 28'($urandom);
    search_valid_i = 1'b1; search_key_i = k;
    upd_idx_i = 5'd17; upd_install_i = 1'b1; upd_value_i = v; upd_care_i = c;
    upd_valid_i = 1'b1;
    @(negedge clk);
    chk("both_search_ready", search_ready_o, 1'b1);
    chk("both_upd_ready", upd_ready_o, 1'b0);
    @(posedge clk); #1;
    search_valid_i = 1'b0;
    @(negedge clk);
    chk("both_upd_ready_next", upd_ready_o, 1'b1);
    chk("both_result_valid", result_valid_o, 1'b1);
    chk("both_result", result_o, ref_result(k));
    @(posedge clk); #1;
    upd_valid_i = 1'b0;
    model_apply(5'd17, 1'b1, v, c);
    finish_update(1'b0);
    do_search(v);

    do_update(5'd30, 1'b1, 28'($urandom), 28'($urandom) & 28'($urandom), 1'b1);
    rand_search(4);

    for (int u = 0; u < 5; u++) begin
      idx = (u == 0) ? 5'(8 + $urandom_range(7)) : 5'($urandom_range(31));
      v = 28'($urandom);
      c = (u % 2 == 1) ? 28'($urandom) : (28'($urandom) & 28'($urandom));
      do_update(idx, (u != 3), v, c, 1'b0);
      do_search(v);
      rand_search(5);
    end

    // Reset in the middle of an update: the rule table must come back empty.
    v = 28'($urandom);
    upd_idx_i = 5'd3; upd_install_i = 1'b1; upd_value_i = v; upd_care_i = 28'h0;
    upd_valid_i = 1'b1;
    @(negedge clk);
    chk("abort_upd_ready", upd_ready_o, 1'b1);
    @(posedge clk); #1;
    upd_valid_i = 1'b0;
    exp_mask = 4'b0001;
    w0 = wr_total;
    repeat (200) @(posedge clk);
    #1;
    chk("abort_rows_written", wr_total - w0, 200);
    rst_ni = 1'b0;
    exp_mask = 4'hF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("abort_rst_busy", busy_o, 1'b0);
    chk("abort_rst_csb", tcam_csb_o, 1'b1);
    @(posedge clk); #1;
    rst_ni = 1'b1;
    for (int r = 0; r < 32; r++) mvalid[r] = 1'b0;
    wait_init();
    do_search(v);
    rand_search(6);
    do_update(5'd4, 1'b1, v, 28'hFFFFFFF, 1'b0);
    do_search(v);
    do_search(v ^ 28'h0000100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
